// File: rtl/foc_dbg_pkg.sv
// Shared types and default sizing for the FOC debug/watchdog blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: watchdog state enum, default parameter values, index-width helper.
package foc_dbg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WATCH   = 2'd1,
      ST_BLOCKED = 2'd2
   } wd_state_t;

   localparam int DEF_N_AXIS = 10;
   localparam int DEF_N_INST = 5;
   localparam int DEF_N_IBLK = 1;
   localparam int DEF_CNT_W  = 16;
   localparam int DEF_EVT_W  = 8;

   // Width of an index into an n-wide vector; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/foc_lowest_set_index.sv
// Lowest-set-bit priority encoder.
// Latency: combinational.
// Backpressure: none.
//
// Ports: vec   - input vector to search
//        idx   - index of the lowest set bit (0 when none set)
//        valid - at least one bit of vec is set
module foc_lowest_set_index
   import foc_dbg_pkg::*;
#(
   parameter int W     = 8,
   parameter int IDX_W = idx_w(W)
)(
   input  logic [W-1:0]     vec,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   // Scanning from the top down lets the lowest set bit be the last writer.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/foc_axis_deadlock_watchdog.sv
// Deadlock watchdog: declares a block after a stall persists for threshold cycles.
// Latency: block follows a qualifying stall by threshold cycles (1 cycle at threshold<=1).
// Backpressure: none; observe-only monitor, inputs are sampled every cycle.
//
// Ports: clock, reset (sync, active-high)
//        axis_block_sigs/axis_mask - per-stream stall flags and monitor enables
//        inst_idle_sigs            - all-idle suppresses detection
//        inst_block_sigs           - per-instance block flags, always monitored
//        threshold, clear          - persistence threshold, sticky/capture clear pulse
//        block, block_sticky       - live and latched block indication
//        first_chan, first_valid   - lowest masked stalled stream at declaration
//        event_count               - saturating count of block declarations
module foc_axis_deadlock_watchdog
   import foc_dbg_pkg::*;
#(
   parameter int N_AXIS = DEF_N_AXIS,
   parameter int N_INST = DEF_N_INST,
   parameter int N_IBLK = DEF_N_IBLK,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int EVT_W  = DEF_EVT_W,
   localparam int CH_W  = idx_w(N_AXIS)
)(
   input  logic              clock,
   input  logic              reset,
   input  logic [N_AXIS-1:0] axis_block_sigs,
   input  logic [N_AXIS-1:0] axis_mask,
   input  logic [N_INST-1:0] inst_idle_sigs,
   input  logic [N_IBLK-1:0] inst_block_sigs,
   input  logic [CNT_W-1:0]  threshold,
   input  logic              clear,
   output logic              block,
   output logic              block_sticky,
   output logic [CH_W-1:0]   first_chan,
   output logic              first_valid,
   output logic [EVT_W-1:0]  event_count
);

   wd_state_t         state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              sticky_nxt, fvalid_nxt, block_nxt;
   logic [CH_W-1:0]   chan_nxt;
   logic [EVT_W-1:0]  evt_nxt, evt_base;

   logic [N_AXIS-1:0] masked;
   logic              all_idle, cand, entry;
   logic [CNT_W-1:0]  thr_eff, cnt_sat;
   logic [CNT_W:0]    cnt_p1;
   logic [CH_W-1:0]   low_idx;
   logic              low_vld;

   assign masked   = axis_block_sigs & axis_mask;
   assign all_idle = &inst_idle_sigs;
   // When every instance reports idle, stall flags are stale and ignored.
   assign cand     = ((|masked) | (|inst_block_sigs)) & ~all_idle;
   assign thr_eff  = (threshold == '0) ? CNT_W'(1) : threshold;
   // One extra bit so cnt+1 compares correctly even when cnt is all-ones.
   assign cnt_p1   = {1'b0, cnt} + (CNT_W + 1)'(1);
   assign cnt_sat  = (&cnt) ? cnt : cnt + CNT_W'(1);

   foc_lowest_set_index #(
      .W     (N_AXIS),
      .IDX_W (CH_W)
   ) u_first (
      .vec   (masked),
      .idx   (low_idx),
      .valid (low_vld)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (cand) begin
               cnt_nxt   = CNT_W'(1);
               state_nxt = (thr_eff == CNT_W'(1)) ? ST_BLOCKED : ST_WATCH;
            end
         end
         ST_WATCH: begin
            if (!cand) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_sat;
               // >= rather than == so a lowered threshold fires immediately.
               if (cnt_p1 >= {1'b0, thr_eff}) begin
                  state_nxt = ST_BLOCKED;
               end
            end
         end
         ST_BLOCKED: begin
            if (!cand) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_sat;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase

      entry     = (state_nxt == ST_BLOCKED) && (state != ST_BLOCKED);
      block_nxt = (state_nxt == ST_BLOCKED);

      // clear is applied first so that a coincident entry overrides it.
      evt_base   = clear ? '0 : event_count;
      sticky_nxt = clear ? 1'b0 : block_sticky;
      chan_nxt   = clear ? '0 : first_chan;
      fvalid_nxt = clear ? 1'b0 : first_valid;
      evt_nxt    = evt_base;
      if (entry) begin
         sticky_nxt = 1'b1;
         evt_nxt    = (&evt_base) ? evt_base : evt_base + EVT_W'(1);
         chan_nxt   = low_idx;
         fvalid_nxt = low_vld;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         block        <= 1'b0;
         block_sticky <= 1'b0;
         first_chan   <= '0;
         first_valid  <= 1'b0;
         event_count  <= '0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         block        <= block_nxt;
         block_sticky <= sticky_nxt;
         first_chan   <= chan_nxt;
         first_valid  <= fvalid_nxt;
         event_count  <= evt_nxt;
      end
   end

endmodule

// File: doc/foc_axis_deadlock_watchdog.md
FOC_AXIS_DEADLOCK_WATCHDOG -- requirements
Module: foc_axis_deadlock_watchdog

Interface
REQ-001 Parameter N_AXIS, default 10: number of AXI-Stream block-sense inputs (1..32).
REQ-002 Parameter N_INST, default 5: number of sub-instance idle inputs (1..16).
REQ-003 Parameter N_IBLK, default 1: number of sub-instance block inputs (1..16).
REQ-004 Parameter CNT_W, default 16: width of the persistence counter and threshold.
REQ-005 Parameter EVT_W, default 8: width of the saturating event counter.
REQ-006 clock  in  1  single clock; all logic rising-edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 axis_block_sigs  in  N_AXIS  per-stream "stalled" flags.
REQ-009 axis_mask  in  N_AXIS  run-time enable per stream; 1 = monitored.
REQ-010 inst_idle_sigs  in  N_INST  per-instance idle flags.
REQ-011 inst_block_sigs  in  N_IBLK  per-instance block flags, always monitored.
REQ-012 threshold  in  CNT_W  consecutive stall cycles required before a block is declared; 0 is treated as 1.
REQ-013 clear  in  1  single-cycle pulse; clears the sticky flag and the capture registers.
REQ-014 block  out  1  live block indication.
REQ-015 block_sticky  out  1  latched block, held until clear or reset.
REQ-016 first_chan  out  clog2(N_AXIS), minimum 1  lowest-index masked stream stalled at declaration.
REQ-017 first_valid  out  1  first_chan is meaningful; 0 when only an inst_block_sigs bit caused the declaration.
REQ-018 event_count  out  EVT_W  number of IDLE/WATCH->BLOCKED entries, saturating.

Function
REQ-019 cand = OR(axis_block_sigs AND axis_mask) OR OR(inst_block_sigs), qualified: cand is forced to 0 while every inst_idle_sigs bit is 1.
REQ-020 States: IDLE, WATCH, BLOCKED; state and all outputs are registered.
REQ-021 IDLE: cand=1 -> WATCH with cnt=1, or directly -> BLOCKED when the effective threshold is 1; cand=0 -> stay in IDLE.
REQ-022 WATCH: cand=1 and cnt+1 >= effective threshold -> BLOCKED; cand=1 otherwise -> cnt increments; cand=0 -> IDLE with cnt=0.
REQ-023 cnt saturates at all-ones and never wraps.
REQ-024 BLOCKED: block=1; cand=0 -> IDLE, block returns to 0 on the next edge, cnt=0.
REQ-025 With threshold=1, block follows cand with exactly 1 cycle latency.
REQ-026 With threshold=T, block rises on the edge at the end of the T-th consecutive cand=1 cycle.
REQ-027 On entry to BLOCKED: block_sticky is set, event_count increments (saturating at 2^EVT_W-1), and first_chan/first_valid are captured from the current inputs.
REQ-028 While BLOCKED, first_chan/first_valid hold and ignore input changes.
REQ-029 clear=1: block_sticky, first_chan, first_valid and event_count go to 0; state, cnt and block are unaffected.
REQ-030 clear coinciding with a BLOCKED entry: entry wins; sticky=1, event_count=1, and the capture is taken.
REQ-031 A threshold change takes effect on the next comparison; if cnt already >= the new threshold while in WATCH, transition to BLOCKED on the next edge with cand=1.
REQ-032 An axis_mask bit dropping mid-WATCH re-evaluates cand that cycle; if cand becomes 0 the state returns to IDLE.

Reset
REQ-033 reset=1: state=IDLE, cnt=0, and block, block_sticky, first_chan, first_valid, event_count all 0 on the next edge.
REQ-034 reset overrides clear and any in-progress WATCH/BLOCKED, including a same-cycle entry.

Structure
REQ-035 Package foc_dbg_pkg holds the state enum and the default parameter constants (N_AXIS, N_INST, N_IBLK, CNT_W, EVT_W).
REQ-036 Sub-module foc_lowest_set_index: combinational lowest-set-bit priority encoder, parametrised width, outputs index and valid; used for first_chan.
REQ-037 No other sub-modules.

Verification
REQ-038 Defaults, threshold=1, axis_mask=all-ones, axis bit3 high for 1 cycle -> block high 1 cycle, 1 cycle late; sticky=1, first_chan=3, event_count=1.
REQ-039 threshold=4, bits 2 and 7 high for 3 cycles then low -> block stays 0, sticky stays 0; bits held 5 cycles -> block rises after cycle 4, first_chan=2.
REQ-040 All 5 inst_idle_sigs=1 with axis bit4 high 20 cycles -> block stays 0; one idle bit dropped -> block asserts per threshold.
REQ-041 Only inst_block_sigs[0] high, threshold=2 -> block after 2 cycles, first_valid=0; axis_mask=0 with axis bits high -> no block.
REQ-042 clear pulsed in the same cycle as a BLOCKED entry -> sticky=1, event_count=1; clear pulsed later -> sticky=0, block unchanged.
REQ-043 EVT_W=2, 5 separate block events -> event_count saturates at 3; reset asserted mid-WATCH -> all outputs 0 on the next edge.
